irq_pending_arbiter: RTL and testbench

// - Upstream request-capture stage for the 4:2 priority encoder path.
// - Turns raw request lines into latched, maskable pending bits.
// - Each cycle, selects the highest-priority unmasked pending bit. Index N-1 is highest.
// - Presents the selected bit as a binary code on a valid/ready handshake.
// - Clears the pending bit when the consumer accepts the code.

---
 rtl/irq_pending_arbiter.sv | 169 ++++++++++++++++
 tb/tb_irq_pending_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: latches rising edges of request lines into maskable pending
// bits, then offers the highest-index unmasked pending bit as a binary code on a
// valid/ready handshake. The accepted bit's pending flag is cleared on the accept.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   req_i        raw request lines (rising-edge sensitive)
//   mask_i       1 = line blocked from selection (still latched as pending)
//   clr_all_i    synchronous flush of all pending bits and of the offer
//   out_valid_o  out_code_o is valid
//   out_ready_i  consumer accepts when out_valid_o & out_ready_i
//   out_code_o   index of the granted line
//   pending_o    registered pending bits
//   any_o        |pending_o
//   overflow_o   1-cycle pulse: a rise hit a bit that was already pending
//
// Latency: req rise to out_valid_o is 2 cycles (4 with IRQ_SYNC_EN).
// Backpressure: while out_ready_i is low the offered code is frozen.
// Optional feature: define IRQ_SYNC_EN to pass req_i through a 2-flop
// synchronizer before edge detection (for requests asynchronous to clk_i).

module irq_pending_arbiter #(
  parameter int N      = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      req_i,
  input  logic [N-1:0]      mask_i,
  input  logic              clr_all_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CODE_W-1:0] out_code_o,
  output logic [N-1:0]      pending_o,
  output logic              any_o,
  output logic              overflow_o
);

  generate
    if (CODE_W != $clog2(N)) begin : g_bad_cfg
      $error("irq_pending_arbiter: CODE_W must equal $clog2(N)");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t              state_q;
  logic [CODE_W-1:0]   out_code_q;
  logic [N-1:0]        pending_q, pending_d;
  logic [N-1:0]        req_q;
  logic                overflow_q, overflow_d;

  logic [N-1:0]        req_s;
  logic [N-1:0]        rise;
  logic                acc;
  logic [N-1:0]        clr_vec;
  logic [N-1:0]        cand;
  logic                cand_any;
  logic [CODE_W-1:0]   sel;

  // ---------------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_i;
`endif

  // ---------------------------------------------------------------------------
  // Edge detect, handshake and candidate selection
  // ---------------------------------------------------------------------------
  assign rise = req_s & ~req_q;
  assign acc  = (state_q == OFFER) & out_ready_i;

  always_comb begin
    clr_vec = '0;
    if (acc) clr_vec[out_code_q] = 1'b1;
  end

  // The bit being accepted this cycle is excluded so a back-to-back reload
  // never re-offers the code that is just leaving.
  assign cand     = pending_q & ~mask_i & ~clr_vec;
  assign cand_any = |cand;

  // Ascending scan: the last hit is the highest set index.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) sel = CODE_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits and overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d  = (pending_q & ~clr_vec) | rise;
    overflow_d = |(rise & pending_q & ~clr_vec);
    if (clr_all_i) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      req_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      req_q      <= req_s;      // tracks even during clr_all so the rise is consumed
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Offer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      out_code_q <= '0;
    end else if (clr_all_i) begin
      state_q    <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_any) begin
            state_q    <= OFFER;
            out_code_q <= sel;
          end
        end
        OFFER: begin
          // Without ready the code stays frozen regardless of new arrivals.
          if (out_ready_i) begin
            if (cand_any) out_code_q <= sel;
            else          state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = (state_q == OFFER);
  assign out_code_o  = out_code_q;
  assign pending_o   = pending_q;
  assign any_o       = |pending_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
module tb_irq_pending_arbiter;

  localparam int N      = 4;
  localparam int CODE_W = 2;
`ifdef IRQ_SYNC_EN
  localparam int EXTRA  = 2;
`else
  localparam int EXTRA  = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0]      mask;
  logic              clr_all;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic [N-1:0]      pending;
  logic              any;
  logic              overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_pending_arbiter #(.N(N), .CODE_W(CODE_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .mask_i      (mask),
    .clr_all_i   (clr_all),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_code_o  (out_code),
    .pending_o   (pending),
    .any_o       (any),
    .overflow_o  (overflow)
  );

  // ---------------------------------------------------------------------------
  // Reference model: per-line event bookkeeping with plain arrays.
  // ---------------------------------------------------------------------------
  bit m_pend [N];
  bit m_last [N];   // last request level seen by the edge detector
  bit m_p1   [N];   // synchronizer stages (unused without IRQ_SYNC_EN)
  bit m_p2   [N];
  bit m_valid;
  int m_code;
  bit m_ovf;
  bit m_started = 1'b0;

  function automatic logic [N-1:0] pack(input bit a [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  always @(posedge clk) begin
    bit seen   [N];
    bit rose   [N];
    bit leaving[N];
    int best;
    bit accepted;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_last[i] = 0; m_p1[i] = 0; m_p2[i] = 0;
      end
      m_valid   = 0;
      m_code    = 0;
      m_ovf     = 0;
      m_started = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (EXTRA != 0) seen[i] = m_p2[i];
        else            seen[i] = req[i];
        rose[i]   = seen[i] && !m_last[i];
        m_last[i] = seen[i];
        m_p2[i]   = m_p1[i];
        m_p1[i]   = req[i];
      end
      if (clr_all) begin
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_valid = 0;
        m_ovf   = 0;
      end else begin
        accepted = m_valid && out_ready;
        for (int i = 0; i < N; i++) leaving[i] = accepted && (i == m_code);
        // highest eligible line, looking at the pending set before this edge
        best = -1;
        for (int i = N - 1; i >= 0; i--) begin
          if (best < 0 && m_pend[i] && !mask[i] && !leaving[i]) best = i;
        end
        m_ovf = 0;
        for (int i = 0; i < N; i++) begin
          if (rose[i] && m_pend[i] && !leaving[i]) m_ovf = 1;
        end
        for (int i = 0; i < N; i++) begin
          m_pend[i] = (m_pend[i] && !leaving[i]) || rose[i];
        end
        if (!m_valid || accepted) begin
          if (best >= 0) begin
            m_valid = 1;
            m_code  = best;
          end else begin
            m_valid = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_started) begin
      checks++;
      if (out_valid !== m_valid || pending !== pack(m_pend) ||
          any !== (|pack(m_pend)) || overflow !== m_ovf ||
          (m_valid && out_code !== CODE_W'(m_code))) begin
        failures++;
        $display("FAIL model t=%0t got v=%b code=%0d pend=%b any=%b ovf=%b exp v=%b code=%0d pend=%b ovf=%b",
                 $time, out_valid, out_code, pending, any, overflow,
                 m_valid, m_code, pack(m_pend), m_ovf);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed literal checks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; req = '0; mask = '0; clr_all = 0; out_ready = 0;
    cyc(2);
    rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_any", 32'(any), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // two lines rise together, consumer always ready
    out_ready = 1; req = 4'b0101;
    cyc(1 + EXTRA);
    chk("s2_pend0", 32'(pending), 32'b0101);
    chk("s2_valid0", 32'(out_valid), 0);
    cyc(1);
    chk("s2_valid1", 32'(out_valid), 1);
    chk("s2_code1", 32'(out_code), 2);
    cyc(1);
    chk("s2_code2", 32'(out_code), 0);
    chk("s2_pend2", 32'(pending), 32'b0001);
    cyc(1);
    chk("s2_valid3", 32'(out_valid), 0);
    chk("s2_pend3", 32'(pending), 0);

    // frozen offer under backpressure
    req = '0; cyc(2);
    req = 4'b0010; out_ready = 0;
    cyc(2 + EXTRA);
    chk("s3_code_a", 32'(out_code), 1);
    req = 4'b1010;
    cyc(2 + EXTRA);
    chk("s3_code_hold", 32'(out_code), 1);
    chk("s3_pend", 32'(pending), 32'b1010);
    out_ready = 1;
    cyc(1);
    chk("s3_code_next", 32'(out_code), 3);
    chk("s3_valid_next", 32'(out_valid), 1);
    cyc(1);
    chk("s3_idle", 32'(out_valid), 0);

    // masked line stays pending until unmasked
    req = '0; cyc(2);
    mask = 4'b1000; req = 4'b1000;
    cyc(3 + EXTRA);
    chk("s4_pend", 32'(pending), 32'b1000);
    chk("s4_masked_valid", 32'(out_valid), 0);
    mask = '0;
    cyc(1);
    chk("s4_valid", 32'(out_valid), 1);
    chk("s4_code", 32'(out_code), 3);
    cyc(1);
    chk("s4_done", 32'(pending), 0);

    // overflow on re-rise, none when re-rise meets the accept
    req = '0; out_ready = 0; cyc(2);
    req = 4'b0100;
    cyc(2 + EXTRA);
    chk("s5_code", 32'(out_code), 2);
    req = '0; cyc(1);
    req = 4'b0100;
    cyc(1 + EXTRA);
    chk("s5_ovf", 32'(overflow), 1);
    chk("s5_pend", 32'(pending), 32'b0100);
    cyc(1);
    chk("s5_ovf_pulse", 32'(overflow), 0);
    req = '0; cyc(1);
    req = 4'b0100;
    cyc(EXTRA);
    out_ready = 1;
    cyc(1);
    chk("s5_acc_ovf", 32'(overflow), 0);
    chk("s5_acc_pend", 32'(pending), 32'b0100);
    cyc(1);
    chk("s5_reoffer", 32'(out_valid), 1);
    chk("s5_reoffer_code", 32'(out_code), 2);
    cyc(1);
    chk("s5_drain", 32'(pending), 0);

    // flush with all pending, offer outstanding and a simultaneous rise
    out_ready = 0; req = '0; cyc(2);
    req = 4'b1110;
    cyc(2 + EXTRA);
    chk("s6_code", 32'(out_code), 3);
    req = 4'b1111;
    cyc(1 + EXTRA);
    chk("s6_pend_full", 32'(pending), 32'b1111);
    req = 4'b1110; cyc(1);
    req = 4'b1111;
    cyc(EXTRA);
    clr_all = 1;
    cyc(1);
    chk("s6_flush_pend", 32'(pending), 0);
    chk("s6_flush_valid", 32'(out_valid), 0);
    chk("s6_flush_ovf", 32'(overflow), 0);
    clr_all = 0;
    cyc(3);
    chk("s6_rise_dropped", 32'(pending), 0);

    // randomized traffic, checked by the model every cycle
    for (int k = 0; k < 3000; k++) begin
      req       = N'($urandom);
      mask      = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      out_ready = ($urandom_range(0, 2) != 0);
      clr_all   = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 250) == 0);
      cyc(1);
    end
    rst = 0; clr_all = 0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
